// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader:
// FSM states, error codes, size defaults and the frame range check.
package imem_loader_pkg;

  localparam int unsigned MEM_DEPTH_DEF  = 1024;
  localparam int unsigned WORD_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_ALIGN = 2'b01,
    ERR_RANGE = 2'b10,
    ERR_CSUM  = 2'b11
  } err_code_e;

  // base + 4*n evaluated 34 bits wide so a huge base cannot wrap into range
  function automatic logic frame_in_range(input logic [31:0]   base,
                                          input logic [15:0]   n,
                                          input int unsigned   depth);
    logic [33:0] frame_end;
    frame_end = {2'b00, base} + {16'b0, n, 2'b00};
    return frame_end <= 34'(depth);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Framed byte-stream loader: parses ADDR/LEN/DATA/CSUM and issues
// big-endian 32-bit word writes to the instruction memory.
import imem_loader_pkg::*;

module imem_loader #(
  parameter int unsigned MEM_DEPTH  = MEM_DEPTH_DEF,
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  wr_en,
  output logic [WORD_WIDTH-1:0] wr_addr,
  output logic [WORD_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code
);

  state_e                  state_q, state_d;
  err_code_e               err_code_q, err_code_d;
  logic [1:0]              lane_q, lane_d;
  logic [WORD_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_hi_q, len_hi_d;
  logic [15:0]             words_left_q, words_left_d;
  logic [WORD_WIDTH-9:0]   word_q, word_d;
  logic [7:0]              csum_q, csum_d;
  logic                    wr_en_q, wr_en_d;
  logic [WORD_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [WORD_WIDTH-1:0]   wr_data_q, wr_data_d;

  logic        accept;
  logic [15:0] len_word;

  assign accept   = rx_valid && rx_ready;
  assign len_word = {len_hi_q, rx_data};

  always_comb begin
    state_d      = state_q;
    err_code_d   = err_code_q;
    lane_d       = lane_q;
    addr_d       = addr_q;
    len_hi_d     = len_hi_q;
    words_left_d = words_left_q;
    word_d       = word_q;
    csum_d       = csum_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_ADDR;
          err_code_d = ERR_NONE;
          lane_d     = '0;
          csum_d     = '0;
        end
      end
      ST_ADDR: begin
        if (accept) begin
          addr_d = {addr_q[WORD_WIDTH-9:0], rx_data};
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            if (rx_data[1:0] != 2'b00) begin
              state_d    = ST_ERR;
              err_code_d = ERR_ALIGN;
            end else begin
              state_d = ST_LEN;
            end
          end
        end
      end
      ST_LEN: begin
        if (accept) begin
          len_hi_d = rx_data;
          lane_d   = lane_q + 2'd1;
          if (lane_q == 2'd1) begin
            lane_d       = '0;
            words_left_d = len_word;
            if (!frame_in_range(addr_q, len_word, MEM_DEPTH)) begin
              state_d    = ST_ERR;
              err_code_d = ERR_RANGE;
            end else if (len_word == 16'd0) begin
              state_d = ST_CSUM;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          word_d = {word_q[WORD_WIDTH-17:0], rx_data};
          csum_d = csum_q + rx_data;
          lane_d = lane_q + 2'd1;
          // Word is emitted from registers so the next byte can be taken
          // in the same cycle the write is presented.
          if (lane_q == 2'd3) begin
            wr_en_d      = 1'b1;
            wr_addr_d    = addr_q;
            wr_data_d    = {word_q, rx_data};
            addr_d       = addr_q + WORD_WIDTH'(4);
            words_left_d = words_left_q - 16'd1;
            if (words_left_q == 16'd1) state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          if (rx_data == csum_q) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_ERR;
            err_code_d = ERR_CSUM;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      err_code_q   <= ERR_NONE;
      lane_q       <= '0;
      addr_q       <= '0;
      len_hi_q     <= '0;
      words_left_q <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      err_code_q   <= err_code_d;
      lane_q       <= lane_d;
      addr_q       <= addr_d;
      len_hi_q     <= len_hi_d;
      words_left_q <= words_left_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign busy     = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                    (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign rx_ready = busy;
  assign done     = (state_q == ST_DONE);
  assign err      = (state_q == ST_ERR);
  assign err_code = err_code_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected word writes are queued as
// frames are driven and matched against wr_en strobes.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  imem_loader #(.MEM_DEPTH(1024), .WORD_WIDTH(32)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [63:0] sb[$];
  logic [7:0]  bytes_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("unexpected_wr", 32'd1, 32'd0);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        check_val("wr_addr", wr_addr, e[63:32]);
        check_val("wr_data", wr_data, e[31:0]);
      end
    end
  end

  task automatic build_frame(input logic [31:0] base, input logic [15:0] n,
                             input logic [7:0] d[$], input logic [7:0] csum);
    bytes_q = {};
    bytes_q.push_back(base[31:24]);
    bytes_q.push_back(base[23:16]);
    bytes_q.push_back(base[15:8]);
    bytes_q.push_back(base[7:0]);
    bytes_q.push_back(n[15:8]);
    bytes_q.push_back(n[7:0]);
    foreach (d[i]) bytes_q.push_back(d[i]);
    bytes_q.push_back(csum);
  endtask

  // Called and returns at a falling edge.
  task automatic send_byte(input logic [7:0] b);
    int unsigned waited;
    waited   = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!rx_ready) begin
      check_val("rdy_timeout", 32'd0, 32'd1);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_stream(input int count, input bit gaps, input int start_at, input bit push);
    logic [31:0] base;
    logic [15:0] n;
    base = {bytes_q[0], bytes_q[1], bytes_q[2], bytes_q[3]};
    n    = {bytes_q[4], bytes_q[5]};
    for (int i = 0; i < count; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        int unsigned k;
        k = ($urandom_range(0, 1) == 0) ? 10 : $urandom_range(1, 9);
        rx_valid = 1'b0;
        repeat (k) @(negedge clk);
      end
      if (i == start_at) begin
        rx_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
      end
      if (push && i >= 6 && i < 6 + 4 * int'(n) && ((i - 6) % 4) == 3) begin
        logic [31:0] a;
        a = base + 32'((i - 6) / 4) * 32'd4;
        sb.push_back({a, bytes_q[i-3], bytes_q[i-2], bytes_q[i-1], bytes_q[i]});
      end
      send_byte(bytes_q[i]);
    end
  endtask

  task automatic start_load();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("start_busy", {31'b0, busy}, 32'd1);
    check_val("start_rdy", {31'b0, rx_ready}, 32'd1);
  endtask

  task automatic check_end(input string tag, input logic d, input logic e, input logic [1:0] code);
    check_val({tag, "_done"}, {31'b0, done}, {31'b0, d});
    check_val({tag, "_err"}, {31'b0, err}, {31'b0, e});
    check_val({tag, "_code"}, {30'b0, err_code}, {30'b0, code});
    check_val({tag, "_rdy"}, {31'b0, rx_ready}, 32'd0);
    check_val({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check_val({tag, "_pending"}, sb.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ctl"}, {24'b0, rx_ready, wr_en, busy, done, err, 1'b0, err_code}, 32'd0);
    check_val({tag, "_addr"}, wr_addr, 32'd0);
    check_val({tag, "_data"}, wr_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] d1[$];
  logic [7:0] d2[$];
  logic [7:0] d0[$];

  initial begin
    d1 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
    d2 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    d0 = {};
    nrst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    nrst = 1'b1;
    @(negedge clk);

    // Basic two-word frame
    build_frame(32'h10, 16'd2, d1, 8'hEA);
    start_load();
    send_stream(bytes_q.size(), 1'b0, -1, 1'b1);
    check_end("frame1", 1'b1, 1'b0, 2'b00);

    // Misaligned base
    build_frame(32'h2, 16'd1, d2, 8'h38);
    start_load();
    send_stream(4, 1'b0, -1, 1'b0);
    check_end("misalign", 1'b0, 1'b1, 2'b01);

    // Out of range, then exactly at the top of memory
    build_frame(32'h3FC, 16'd2, d1, 8'hEA);
    start_load();
    send_stream(6, 1'b0, -1, 1'b0);
    check_end("range", 1'b0, 1'b1, 2'b10);
    build_frame(32'h3FC, 16'd1, d2, 8'h38);
    start_load();
    send_stream(bytes_q.size(), 1'b0, -1, 1'b1);
    check_end("top", 1'b1, 1'b0, 2'b00);

    // Empty frame, good and bad checksum
    build_frame(32'h10, 16'd0, d0, 8'h00);
    start_load();
    send_stream(bytes_q.size(), 1'b0, -1, 1'b1);
    check_end("empty", 1'b1, 1'b0, 2'b00);
    build_frame(32'h10, 16'd0, d0, 8'h01);
    start_load();
    send_stream(bytes_q.size(), 1'b0, -1, 1'b1);
    check_end("badsum", 1'b0, 1'b1, 2'b11);

    // Valid gaps plus an ignored start mid-frame
    for (int r = 0; r < 3; r++) begin
      build_frame(32'h10, 16'd2, d1, 8'hEA);
      start_load();
      send_stream(bytes_q.size(), 1'b1, 7 + r, 1'b1);
      check_end("gaps", 1'b1, 1'b0, 2'b00);
    end

    // Reset after the fifth data byte
    build_frame(32'h10, 16'd2, d1, 8'hEA);
    start_load();
    send_stream(11, 1'b0, -1, 1'b1);
    nrst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    nrst = 1'b1;
    repeat (20) @(negedge clk);
    check_val("midreset_pending", sb.size(), 32'd0);
    check_reset_outputs("midreset_idle");
    start_load();
    send_stream(bytes_q.size(), 1'b0, -1, 1'b1);
    check_end("reload", 1'b1, 1'b0, 2'b00);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the byte-addressable, big-endian instruction memory. It accepts a framed byte stream over a valid/ready handshake and assembles 32-bit words. It issues one word write per four data bytes and holds the CPU while loading. It is the write-side counterpart of the synchronous instruction-fetch read port; bytes land so that `memory[a]` holds the MSB of the word at `a`.

## Interface
- `MEM_DEPTH`, 1024: instruction memory size in bytes.
- `WORD_WIDTH`, 32: data word width.
- `clk` in 1: single clock, rising edge.
- `nrst` in 1: reset, synchronous, active-low.
- `start` in 1: single-cycle request to begin a load; ignored while `busy`.
- `rx_data` in 8: stream byte.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: loader accepts a byte; transfer occurs when `rx_valid && rx_ready` at a rising edge.
- `wr_en` out 1: one-cycle word write strobe to instruction memory.
- `wr_addr` out `WORD_WIDTH`: byte address of the word write; always a multiple of 4.
- `wr_data` out `WORD_WIDTH`: word to write, `{b0,b1,b2,b3}` in arrival order.
- `busy` out 1: load in progress; also drives the CPU hold.
- `done` out 1: load completed successfully; sticky.
- `err` out 1: load aborted; sticky.
- `err_code` out 2: error cause: 01 misaligned base, 10 out of range, 11 checksum mismatch, 00 none.

## Operation
- Frame format: `ADDR` (4 bytes, big-endian base address), `LEN` (2 bytes, big-endian word count N), `DATA` (4N bytes), `CSUM` (1 byte).
- `CSUM` is the modulo-256 sum of all DATA bytes.
- FSM states: IDLE, ADDR, LEN, DATA, CSUM, DONE, ERR.
  - IDLE/DONE/ERR → ADDR on `start`. This clears `done`, `err`, `err_code`, the byte counter and the running checksum.
  - ADDR → LEN after the 4th address byte, if base[1:0] == 0. Otherwise → ERR with code 01.
  - LEN → DATA after the 2nd length byte, if base + 4N ≤ `MEM_DEPTH`, computed 34 bits wide with no wrap. Otherwise → ERR with code 10.
  - N == 0 → CSUM directly, and the expected checksum is 0x00.
  - DATA → CSUM after byte 4N.
  - CSUM → DONE if the received byte equals the running sum. Otherwise → ERR with code 11.
- Word k is written to address base + 4k. A 2-bit byte-lane counter shifts bytes into a word register; the 32-bit address register increments by 4 after each write.
- `rx_ready` is 1 only in ADDR, LEN, DATA and CSUM. The loader never stalls the stream; a write proceeds in parallel with reception of the next byte.
- `busy` is 1 in ADDR through CSUM.
- `done` is 1 in DONE and `err` is 1 in ERR. Both hold until the next `start` or reset.
- Writes already issued before an ERR are not undone.
- Reset mid-frame returns the block to IDLE. The partially received frame is discarded and no further `wr_en` is issued.

## Timing
- Reset values: `rx_ready` 0, `wr_en` 0, `wr_addr` 0, `wr_data` 0, `busy` 0, `done` 0, `err` 0, `err_code` 00; state IDLE.
- `start` sampled high at edge t: `busy` and `rx_ready` are 1 from t+1.
- 4th byte of a data word accepted at edge t: `wr_en` = 1 for exactly the cycle after t, with `wr_addr`/`wr_data` stable during it. `wr_data` may change after `wr_en` drops.
- Last header byte or checksum byte accepted at edge t: `err`/`done` and the new state are visible from t+1, with `rx_ready` = 0 at the same time.
- `start` while `busy` has no effect.
- `start` and `nrst` low in the same cycle: reset wins.
- `rx_valid` low: no state change; gaps of any length are allowed.

## Structure
- Error codes, state encodings and `WORD_WIDTH`/`MEM_DEPTH` defaults go in the shared `defines.h` header, next to `INPUT_DELAY`.
- Single flat module. No sub-module is needed; the byte-to-word packer is inline (counter plus shift register).

## Test plan
- Base 0x00000010, N=2, data 01 02 03 04 A0 B0 C0 D0, CSUM 0xEA → writes (0x10, 0x01020304), (0x14, 0xA0B0C0D0); `done`=1, `err`=0.
- Base 0x00000002 → `err`=1, `err_code`=01 the cycle after the 4th byte; no `wr_en`; `rx_ready`=0.
- Base 0x3FC with N=2 → `err_code`=10 after the LEN bytes, no writes. Base 0x3FC with N=1, data DE AD BE EF, CSUM 0x38 → write (0x3FC, 0xDEADBEEF); `done`=1.
- N=0, CSUM 0x00 → `done`=1 with no writes. Same frame with CSUM 0x01 → `err_code`=11.
- Same frame as the first test with `rx_valid` randomly toggled, including 10-cycle gaps → identical writes and `done`. A `start` pulse mid-frame is ignored.
- `nrst` low for one cycle after the 5th data byte of the first test's frame → all outputs at reset values the next cycle, no further `wr_en`. A new `start` plus the full frame then completes normally.
